uart_mmio_periph: RTL and testbench
===================================

// Module: uart_mmio_periph
// PURPOSE
//   Memory-mapped UART peripheral on the MEM-stage data bus, downstream of EX/MEM and alongside data memory.
//   - Serialises bytes written by the CPU onto uart_tx.
//   - Deserialises uart_rx into a readable holding register.
//   - Raises a level interrupt toward the hazard/ID logic.
//   - Format: 8N1, LSB first.
// PARAMETERS
//   CLK_HZ      50_000_000  system clock frequency
//   BAUD        9600        line rate
//   OVERSAMPLE  16          ticks per bit; DIV = CLK_HZ/(BAUD*OVERSAMPLE), integer, >=2
// PORTS
//   clk       in   1   system clock, all logic on rising edge
//   reset     in   1   synchronous, active-high reset
//   addr      in   32  byte address from the EX/MEM ALU result
//   wdata     in   32  store data (rt), low byte used
//   mem_wr    in   1   store strobe, one cycle per access
//   mem_rd    in   1   load strobe, one cycle per access
//   rdata     out  32  load data, combinational from addr; 0 when no register matches
//   uart_rx   in   1   asynchronous serial input
//   uart_tx   out  1   serial output, idle high
//   irq       out  1   level interrupt
// BEHAVIOUR
//   Register map (word addresses; other addresses ignored, rdata=0):
//     0x40000018 TXD  W: byte to send. R: last written byte.
//     0x4000001C RXD  R: received byte in [7:0]. Read with mem_rd pops the byte (rx_valid<=0 / FIFO pop).
//     0x40000020 CON  R/W [1]rx_ie [0]tx_ie. R-only: [2]tx_done [3]rx_valid [4]tx_busy [5]overrun [6]frame_err.
//       Read of CON clears tx_done, overrun and frame_err on that edge.
//   Reset: uart_tx=1, irq=0, all flags/ie=0, both FSMs IDLE, baud counter 0.
//   Baud tick: one-cycle pulse every DIV clocks, free-running from reset.
//   TX FSM: IDLE->START->DATA(8 bits)->STOP->IDLE, OVERSAMPLE ticks per bit.
//     - A TXD write in IDLE latches the byte, sets tx_busy and clears tx_done.
//     - START begins on the next tick.
//     - Leaving STOP clears tx_busy and sets tx_done.
//     - A TXD write while tx_busy is dropped; no state change.
//   RX path: uart_rx passes through a 2-flop synchroniser; the FSM uses the synced value.
//   RX FSM: IDLE->START->DATA->STOP->IDLE.
//     - A low in IDLE starts START.
//     - START samples at tick OVERSAMPLE/2. High there is a false start -> IDLE.
//     - DATA samples bits at mid-bit; STOP samples at mid-bit.
//     - Stop bit =0: byte discarded, frame_err=1, FSM -> IDLE.
//     - Stop bit =1: byte stored on the cycle STOP is sampled.
//   Overrun: a byte stored while the store is full overwrites the held byte and sets overrun=1.
//   Simultaneous RXD-read pop and byte store on the same edge: the read returns the old byte; the new byte is stored; rx_valid stays 1.
//   irq = (rx_valid & rx_ie) | (tx_done & tx_ie), registered, 1-cycle latency.
//   Reset mid-frame: both FSMs abort immediately; the partial byte is lost; uart_tx goes high on the next edge.
// CONFIGURATION
//   UART_RX_FIFO_EN defined:
//     - RX store is a 4-entry FIFO; rx_valid = !empty.
//     - A byte stored when full is dropped (old data kept) and sets overrun.
//     - Push and pop in the same cycle when full both succeed.
//     - CON[9:7] = entry count.
//   Undefined:
//     - Single holding register with overwrite-on-overrun as above.
//     - CON[9:7] read 0.
// STRUCTURE
//   uart_pkg:
//     - address constants UART_TXD_ADDR / UART_RXD_ADDR / UART_CON_ADDR
//     - CON bit-index localparams
//     - uart_state_t enum {IDLE, START, DATA, STOP}
//     - baud_div function
//   Sub-module uart_baud_gen: DIV counter producing a tick pulse; shared by TX and RX.
//   TX FSM, RX FSM, register decode and the optional FIFO stay in this module.
// TESTING (bench with DIV=4 via CLK_HZ=64*BAUD, OVERSAMPLE=16)
//   1. Write TXD=0x55 -> uart_tx: start 0, bits 1,0,1,0,1,0,1,0, stop 1, each 64 clk; tx_busy 1 until stop ends; tx_done=1 after.
//   2. Drive 0xA3 8N1 on uart_rx with rx_ie=1 -> rx_valid=1, irq=1 next cycle.
//      Read RXD -> rdata[7:0]=0xA3, rx_valid=0, irq=0 one cycle later.
//   3. Glitch uart_rx low for 20 clk -> false start, no byte stored, FSM returns IDLE.
//      A frame with stop=0 -> frame_err=1, rx_valid stays 0.
//   4. Receive 0x11 then 0x22 without reading:
//      - FIFO undefined: RXD=0x22, overrun=1.
//      - FIFO defined: reads return 0x11 then 0x22; 5 unread bytes -> overrun=1 and 5th byte dropped.
//   5. Write TXD=0x0F, then TXD=0xF0 mid-frame -> only 0x0F transmitted.
//      Assert reset during the DATA bit -> uart_tx=1 next edge; CON reads 0.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - UART peripheral register map, CON bit indices, FSM state type, baud divider helper
package uart_pkg;

  localparam logic [31:0] UART_TXD_ADDR = 32'h4000_0018;
  localparam logic [31:0] UART_RXD_ADDR = 32'h4000_001C;
  localparam logic [31:0] UART_CON_ADDR = 32'h4000_0020;

  localparam int CON_TX_IE     = 0;
  localparam int CON_RX_IE     = 1;
  localparam int CON_TX_DONE   = 2;
  localparam int CON_RX_VALID  = 3;
  localparam int CON_TX_BUSY   = 4;
  localparam int CON_OVERRUN   = 5;
  localparam int CON_FRAME_ERR = 6;
  localparam int CON_CNT_LSB   = 7;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  function automatic int baud_div(input int clk_hz, input int baud, input int oversample);
    return clk_hz / (baud * oversample);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - free-running divider emitting a one-cycle oversample tick every DIV clocks
module uart_baud_gen #(
  parameter int DIV = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;

  assign o_tick = (r_cnt == CW'(DIV - 1));

  // Count 0..DIV-1 and wrap; the tick is the terminal count.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_mmio_periph.sv
// rtl/uart_mmio_periph.sv - memory-mapped 8N1 UART with TX/RX FSMs and irq; UART_RX_FIFO_EN selects 4-entry RX FIFO
module uart_mmio_periph
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic        i_mem_wr,
  input  logic        i_mem_rd,
  output logic [31:0] o_rdata,
  input  logic        i_uart_rx,
  output logic        o_uart_tx,
  output logic        o_irq
);

  localparam int DIV = baud_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int CW  = $clog2(OVERSAMPLE);

  logic w_tick;
  logic w_sel_txd, w_sel_rxd, w_sel_con;
  logic w_wr_txd, w_wr_con, w_rd_rxd, w_rd_con;
  logic w_unused;

  uart_baud_gen #(.DIV(DIV)) u_baud (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .o_tick (w_tick)
  );

  assign w_sel_txd = (i_addr[31:2] == UART_TXD_ADDR[31:2]);
  assign w_sel_rxd = (i_addr[31:2] == UART_RXD_ADDR[31:2]);
  assign w_sel_con = (i_addr[31:2] == UART_CON_ADDR[31:2]);
  assign w_wr_txd  = i_mem_wr & w_sel_txd;
  assign w_wr_con  = i_mem_wr & w_sel_con;
  assign w_rd_rxd  = i_mem_rd & w_sel_rxd;
  assign w_rd_con  = i_mem_rd & w_sel_con;
  assign w_unused  = &{1'b0, i_wdata[31:8], i_addr[1:0]};

  // ---------------- TX ----------------
  uart_state_t   r_tx_state, w_tx_nx;
  logic [CW-1:0] r_tx_cnt;
  logic [2:0]    r_tx_bit;
  logic [7:0]    r_tx_shift, r_txd;
  logic          r_tx_busy, r_tx_done, r_tx_ie, r_rx_ie;
  logic          w_tx_bit_end, w_tx_finish;

  assign w_tx_bit_end = w_tick && (r_tx_cnt == CW'(OVERSAMPLE - 1));

  // TX state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_tx_state <= IDLE;
    else         r_tx_state <= w_tx_nx;
  end

  // TX next state; a pending byte waits in IDLE for the next tick.
  always_comb begin
    w_tx_nx     = r_tx_state;
    w_tx_finish = 1'b0;
    case (r_tx_state)
      IDLE:  if (r_tx_busy && w_tick) w_tx_nx = START;
      START: if (w_tx_bit_end) w_tx_nx = DATA;
      DATA:  if (w_tx_bit_end && (r_tx_bit == 3'd7)) w_tx_nx = STOP;
      STOP:  if (w_tx_bit_end) begin
               w_tx_nx     = IDLE;
               w_tx_finish = 1'b1;
             end
      default: w_tx_nx = IDLE;
    endcase
  end

  // Line level follows the state: start low, data LSB first, idle/stop high.
  always_comb begin
    o_uart_tx = 1'b1;
    if (r_tx_state == START)     o_uart_tx = 1'b0;
    else if (r_tx_state == DATA) o_uart_tx = r_tx_shift[0];
  end

  // TX datapath: tick counter, bit index, shifter and busy/done flags.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_txd      <= '0;
      r_tx_busy  <= 1'b0;
      r_tx_done  <= 1'b0;
    end else begin
      if (r_tx_state == IDLE) begin
        r_tx_cnt <= '0;
        r_tx_bit <= '0;
      end else if (w_tick) begin
        r_tx_cnt <= w_tx_bit_end ? '0 : r_tx_cnt + CW'(1);
      end
      if ((r_tx_state == DATA) && w_tx_bit_end) begin
        r_tx_shift <= r_tx_shift >> 1;
        r_tx_bit   <= r_tx_bit + 3'd1;
      end
      if (w_wr_txd && !r_tx_busy) begin
        r_txd      <= i_wdata[7:0];
        r_tx_shift <= i_wdata[7:0];
        r_tx_busy  <= 1'b1;
        r_tx_done  <= 1'b0;
      end else if (w_rd_con) begin
        r_tx_done <= 1'b0;
      end
      if (w_tx_finish) begin
        r_tx_busy <= 1'b0;
        r_tx_done <= 1'b1;
      end
    end
  end

  // ---------------- RX ----------------
  uart_state_t   r_rx_state, w_rx_nx;
  logic [CW-1:0] r_rx_cnt;
  logic [2:0]    r_rx_bit;
  logic [7:0]    r_rx_shift;
  logic          r_rx_s1, r_rx_s2;
  logic          r_frame_err, r_overrun;
  logic          w_rx_half, w_rx_bit_end, w_rx_store, w_rx_ferr;
  logic          w_rx_valid, w_ovr_set;
  logic [7:0]    w_rx_byte;
  logic [2:0]    w_rx_count;

  assign w_rx_half    = w_tick && (r_rx_cnt == CW'(OVERSAMPLE / 2 - 1));
  assign w_rx_bit_end = w_tick && (r_rx_cnt == CW'(OVERSAMPLE - 1));

  // Two-flop synchroniser for the asynchronous serial input.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
    end else begin
      r_rx_s1 <= i_uart_rx;
      r_rx_s2 <= r_rx_s1;
    end
  end

  // RX state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_rx_state <= IDLE;
    else         r_rx_state <= w_rx_nx;
  end

  // RX next state; START re-checks the line at half a bit to reject glitches.
  always_comb begin
    w_rx_nx    = r_rx_state;
    w_rx_store = 1'b0;
    w_rx_ferr  = 1'b0;
    case (r_rx_state)
      IDLE:  if (!r_rx_s2) w_rx_nx = START;
      START: if (w_rx_half) w_rx_nx = r_rx_s2 ? IDLE : DATA;
      DATA:  if (w_rx_bit_end && (r_rx_bit == 3'd7)) w_rx_nx = STOP;
      STOP:  if (w_rx_bit_end) begin
               w_rx_nx = IDLE;
               if (r_rx_s2) w_rx_store = 1'b1;
               else         w_rx_ferr  = 1'b1;
             end
      default: w_rx_nx = IDLE;
    endcase
  end

  // RX datapath: counter realigned to mid-bit at the start check, bit shifter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      if ((r_rx_state == IDLE) || ((r_rx_state == START) && w_rx_half)) begin
        r_rx_cnt <= '0;
      end else if (w_tick) begin
        r_rx_cnt <= w_rx_bit_end ? '0 : r_rx_cnt + CW'(1);
      end
      if (r_rx_state != DATA) begin
        r_rx_bit <= '0;
      end else if (w_rx_bit_end) begin
        r_rx_bit   <= r_rx_bit + 3'd1;
        r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
      end
    end
  end

`ifdef UART_RX_FIFO_EN
  logic [7:0] r_fifo [4];
  logic [1:0] r_wp, r_rp;
  logic [2:0] r_cnt;
  logic       w_pop, w_push;

  assign w_pop      = w_rd_rxd && (r_cnt != 3'd0);
  assign w_push     = w_rx_store && ((r_cnt != 3'd4) || w_pop);
  assign w_ovr_set  = w_rx_store && (r_cnt == 3'd4) && !w_pop;
  assign w_rx_valid = (r_cnt != 3'd0);
  assign w_rx_byte  = w_rx_valid ? r_fifo[r_rp] : 8'h00;
  assign w_rx_count = r_cnt;

  // FIFO storage; contents are only visible while the entry count covers them.
  always_ff @(posedge i_clk) begin
    if (w_push) r_fifo[r_wp] <= r_rx_shift;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 2'd1;
      if (w_pop)  r_rp <= r_rp + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 3'd1;
        2'b01:   r_cnt <= r_cnt - 3'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end
`else
  logic [7:0] r_rx_data;
  logic       r_rx_valid;

  assign w_ovr_set  = w_rx_store && r_rx_valid && !w_rd_rxd;
  assign w_rx_valid = r_rx_valid;
  assign w_rx_byte  = r_rx_data;
  assign w_rx_count = 3'd0;

  // Single holding register; a new byte always wins over a pop on the same edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else if (w_rx_store) begin
      r_rx_data  <= r_rx_shift;
      r_rx_valid <= 1'b1;
    end else if (w_rd_rxd) begin
      r_rx_valid <= 1'b0;
    end
  end
`endif

  // Sticky error flags and interrupt enables; a CON read clears the errors.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      r_tx_ie     <= 1'b0;
      r_rx_ie     <= 1'b0;
    end else begin
      if (w_rx_ferr)     r_frame_err <= 1'b1;
      else if (w_rd_con) r_frame_err <= 1'b0;
      if (w_ovr_set)     r_overrun <= 1'b1;
      else if (w_rd_con) r_overrun <= 1'b0;
      if (w_wr_con) begin
        r_tx_ie <= i_wdata[CON_TX_IE];
        r_rx_ie <= i_wdata[CON_RX_IE];
      end
    end
  end

  // Registered level interrupt.
  always_ff @(posedge i_clk) begin
    if (i_reset) o_irq <= 1'b0;
    else         o_irq <= (w_rx_valid & r_rx_ie) | (r_tx_done & r_tx_ie);
  end

  // Combinational read mux driven by address alone.
  always_comb begin
    o_rdata = '0;
    if (w_sel_txd) begin
      o_rdata[7:0] = r_txd;
    end else if (w_sel_rxd) begin
      o_rdata[7:0] = w_rx_byte;
    end else if (w_sel_con) begin
      o_rdata[CON_TX_IE]            = r_tx_ie;
      o_rdata[CON_RX_IE]            = r_rx_ie;
      o_rdata[CON_TX_DONE]          = r_tx_done;
      o_rdata[CON_RX_VALID]         = w_rx_valid;
      o_rdata[CON_TX_BUSY]          = r_tx_busy;
      o_rdata[CON_OVERRUN]          = r_overrun;
      o_rdata[CON_FRAME_ERR]        = r_frame_err;
      o_rdata[CON_CNT_LSB +: 3]     = w_rx_count;
    end
  end

endmodule

// File: tb/tb_uart_mmio_periph.sv
// tb/tb_uart_mmio_periph.sv - self-checking bench for uart_mmio_periph (DIV=4, OVERSAMPLE=16)
module tb_uart_mmio_periph;

  localparam int BAUD   = 9600;
  localparam int CLK_HZ = 64 * BAUD;
  localparam int OS     = 16;
  localparam int BITCLK = 64;
  localparam logic [31:0] A_TXD = 32'h4000_0018;
  localparam logic [31:0] A_RXD = 32'h4000_001C;
  localparam logic [31:0] A_CON = 32'h4000_0020;
`ifdef UART_RX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr, wdata;
  logic        mem_wr, mem_rd;
  logic [31:0] rdata;
  logic        uart_rx;
  logic        uart_tx, irq;

  int errors = 0;
  int checks = 0;

  logic [7:0] mq[$];
  logic       m_ovr;

  uart_mmio_periph #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS)) dut (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_addr   (addr),
    .i_wdata  (wdata),
    .i_mem_wr (mem_wr),
    .i_mem_rd (mem_rd),
    .o_rdata  (rdata),
    .i_uart_rx(uart_rx),
    .o_uart_tx(uart_tx),
    .o_irq    (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; mem_wr = 1'b1;
    @(negedge clk);
    mem_wr = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a; mem_rd = 1'b1;
    #1 d = rdata;
    @(negedge clk);
    mem_rd = 1'b0; addr = '0;
  endtask

  task automatic peek(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a;
    #1 d = rdata;
    addr = '0;
  endtask

  function automatic void m_push(input logic [7:0] b);
    if (mq.size() < DEPTH) mq.push_back(b);
    else begin
      if (DEPTH == 1) mq[0] = b;
      m_ovr = 1'b1;
    end
  endfunction

  task automatic rx_frame(input logic [7:0] b, input logic stop_ok);
    uart_rx = 1'b0;
    repeat (BITCLK) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (BITCLK) @(negedge clk);
    end
    if (!stop_ok) begin
      uart_rx = 1'b0;
      repeat (40) @(negedge clk);
    end
    uart_rx = 1'b1;
    repeat (BITCLK) @(negedge clk);
  endtask

  task automatic check_rx(input string tag);
    logic [31:0] c, d;
    peek(A_CON, c);
    chk({tag, "_rx_valid"}, c[3], 32'(mq.size() != 0));
    chk({tag, "_overrun"}, c[5], m_ovr);
    chk({tag, "_count"}, c[9:7], (DEPTH > 1) ? mq.size() : 0);
    if (mq.size() != 0) begin
      peek(A_RXD, d);
      chk({tag, "_rxd"}, d, {24'h0, mq[0]});
    end
  endtask

  task automatic tx_frame(input logic [7:0] b, input bit inject, input logic [7:0] junk);
    logic [31:0] c;
    logic [9:0]  frame;
    int n, spent, lows;
    frame = {1'b1, b, 1'b0};
    bus_wr(A_TXD, {24'h0, b});
    n = 0;
    while (uart_tx !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("tx_start_seen", 32'(n < 200), 1);
    spent = 0;
    for (int k = 0; k < 10; k++) begin
      repeat (((k == 0) ? BITCLK / 2 : BITCLK) - spent) @(negedge clk);
      spent = 0;
      chk($sformatf("tx_bit%0d", k), uart_tx, frame[k]);
      if (k == 2) begin
        peek(A_CON, c);
        spent = 1;
        chk("tx_busy_mid", c[4], 1);
        chk("tx_done_cleared", c[2], 0);
      end
      if (k == 3 && inject) begin
        bus_wr(A_TXD, {24'h0, junk});
        spent = 2;
      end
    end
    repeat (40) @(negedge clk);
    peek(A_CON, c);
    chk("tx_busy_end", c[4], 0);
    chk("tx_done_end", c[2], 1);
    peek(A_TXD, c);
    chk("txd_readback", c, {24'h0, b});
    lows = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    chk("tx_idle_after", lows, 0);
  endtask

  initial begin
    logic [31:0] c, d;
    logic [7:0]  b;
    logic [7:0]  bytes [5];
    int n, nb, lows;

    reset = 1'b1; addr = '0; wdata = '0; mem_wr = 1'b0; mem_rd = 1'b0; uart_rx = 1'b1;
    m_ovr = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_uart_tx", uart_tx, 1);
    chk("rst_irq", irq, 0);
    peek(A_CON, c); chk("rst_con", c, 0);
    peek(A_RXD, c); chk("rst_rxd", c, 0);
    peek(A_TXD, c); chk("rst_txd", c, 0);
    peek(32'h4000_0024, c); chk("unmapped_zero", c, 0);

    // TX: 0x55 then random bytes
    tx_frame(8'h55, 1'b0, 8'h00);
    bus_wr(A_CON, 32'h1);
    @(negedge clk);
    chk("irq_tx_done", irq, 1);
    bus_rd(A_CON, c);
    chk("con_read_done", c[2], 1);
    peek(A_CON, c);
    chk("done_cleared_by_read", c[2], 0);
    chk("irq_tx_clear", irq, 0);
    bus_wr(A_CON, 32'h0);
    for (int i = 0; i < 2; i++) tx_frame(8'($urandom_range(0, 255)), 1'b0, 8'h00);

    // RX 0xA3 with rx_ie, irq latency
    bus_wr(A_CON, 32'h2);
    uart_rx = 1'b0;
    repeat (BITCLK) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      b = 8'hA3;
      uart_rx = b[i];
      repeat (BITCLK) @(negedge clk);
    end
    uart_rx = 1'b1;
    addr = A_CON;
    n = 0;
    while (rdata[3] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rx_valid_seen", 32'(n < 100), 1);
    chk("irq_not_yet", irq, 0);
    @(negedge clk);
    chk("irq_rx", irq, 1);
    addr = '0;
    repeat (BITCLK) @(negedge clk);
    m_push(8'hA3);
    bus_rd(A_RXD, d);
    chk("rxd_a3", d, {24'h0, mq[0]});
    void'(mq.pop_front());
    chk("irq_hold_after_pop", irq, 1);
    peek(A_CON, c);
    chk("rx_valid_popped", c[3], 0);
    chk("irq_rx_clear", irq, 0);
    bus_wr(A_CON, 32'h0);

    // RX random bytes against the model
    for (int i = 0; i < 2; i++) begin
      b = 8'($urandom_range(0, 255));
      rx_frame(b, 1'b1);
      m_push(b);
      check_rx($sformatf("rx_rand%0d", i));
      bus_rd(A_RXD, d);
      chk("rx_rand_pop", d, {24'h0, mq[0]});
      void'(mq.pop_front());
    end

    // Glitch, then framing error, then recovery
    uart_rx = 1'b0;
    repeat (20) @(negedge clk);
    uart_rx = 1'b1;
    repeat (150) @(negedge clk);
    check_rx("glitch");
    rx_frame(8'($urandom_range(0, 255)), 1'b0);
    peek(A_CON, c);
    chk("frame_err_set", c[6], 1);
    chk("frame_err_no_byte", c[3], 0);
    bus_rd(A_CON, c);
    chk("frame_err_read", c[6], 1);
    peek(A_CON, c);
    chk("frame_err_cleared", c[6], 0);
    rx_frame(8'h5A, 1'b1);
    m_push(8'h5A);
    check_rx("recover");
    bus_rd(A_RXD, d);
    void'(mq.pop_front());

    // Overrun
    bytes[0] = 8'h11;
    bytes[1] = 8'h22;
    for (int i = 2; i < 5; i++) bytes[i] = 8'($urandom_range(0, 255));
    nb = (DEPTH > 1) ? 5 : 2;
    for (int i = 0; i < nb; i++) begin
      rx_frame(bytes[i], 1'b1);
      m_push(bytes[i]);
    end
    check_rx("overrun");
    while (mq.size() != 0) begin
      bus_rd(A_RXD, d);
      chk("drain", d, {24'h0, mq[0]});
      void'(mq.pop_front());
    end
    bus_rd(A_CON, c);
    m_ovr = 1'b0;
    check_rx("overrun_cleared");

    // Write while busy is dropped
    tx_frame(8'h0F, 1'b1, 8'hF0);

    // Reset mid-frame with a pending interrupt
    bus_wr(A_CON, 32'h2);
    rx_frame(8'h3C, 1'b1);
    m_push(8'h3C);
    @(negedge clk);
    chk("irq_before_reset", irq, 1);
    bus_wr(A_TXD, {24'h0, 8'($urandom_range(0, 255))});
    n = 0;
    while (uart_tx !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reset_tx_started", 32'(n < 200), 1);
    repeat (BITCLK / 2 + 2 * BITCLK) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_uart_tx", uart_tx, 1);
    chk("reset_irq", irq, 0);
    peek(A_CON, c);
    chk("reset_con", c, 0);
    reset = 1'b0;
    mq.delete();
    m_ovr = 1'b0;
    lows = 0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    chk("reset_tx_aborted", lows, 0);
    check_rx("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
